// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the reduced RV32I board core.
//   - RV32I opcode / funct3 / funct7 encodings for the supported subset
//   - ALU operation enum
//   - 16-entry active-low 7-segment lookup (bit order gfedcba)
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_t;

  // Entry n holds the active-low segment pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/riscv_seg_display.sv
// riscv_seg_display: 4-digit multiplexed common-anode 7-segment driver.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-low
//   value   - 16-bit value to show, digit 0 = value[3:0] (rightmost)
//   anode   - active-low digit enables, registered
//   cathode - active-low segments a..g (cathode[0]=a), registered
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, zero digits above
// the most significant nonzero digit are blanked (digit 0 always shown).
module riscv_seg_display
  import riscv_pkg::*;
#(
  parameter int DIG_DIV_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  logic [DIG_DIV_BITS+1:0] scan_cnt;
  logic [1:0]              digit;
  logic [3:0]              nibble;
  logic                    blank;

  // The top two counter bits select the digit, so each digit is held for
  // 2^DIG_DIV_BITS clocks.
  assign digit  = scan_cnt[DIG_DIV_BITS+1:DIG_DIV_BITS];
  assign nibble = value[{digit, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    unique case (digit)
      2'd3:    blank = (value[15:12] == 4'h0);
      2'd2:    blank = (value[15:8] == 8'h00);
      2'd1:    blank = (value[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Outputs are registered from the current digit index, so they trail the
  // counter by one clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      anode    <= 4'b1110;
      cathode  <= SEG_LUT[0];
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      anode    <= ~(4'b0001 << digit);
      cathode  <= blank ? 7'b1111111 : SEG_LUT[nibble];
    end
  end

endmodule

// File: rtl/riscv.sv
// riscv: reduced single-cycle RV32I core (ADD, SUB, AND, OR, ADDI, LW, SW, BEQ)
// with a fixed program ROM, 32x32 register file and small data RAM, showing
// one result register on a multiplexed 7-segment display.
// Ports:
//   clk     - 50 MHz system clock, rising edge
//   reset   - synchronous, active-low
//   sel     - display source: 00=x3, 01=x4, 10=x5, 11=x6
//   wr      - 1: display latch follows selected register, 0: latch holds
//   anode   - active-low digit enables (anode[0] = rightmost digit)
//   cathode - active-low segments (cathode[0]=a .. cathode[6]=g)
// Optional build macro LEADING_ZERO_BLANK_EN (passed to the display driver).
module riscv
  import riscv_pkg::*;
#(
  parameter int DIG_DIV_BITS = 16,
  parameter int IMEM_WORDS   = 16,
  parameter int DMEM_WORDS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       wr,
  output logic [3:0] anode,
  output logic [6:0] cathode
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  // The PC only spans the ROM, so it wraps back to 0 past the last word.
  localparam logic [31:0] PC_MASK = 32'((64'd1 << (IW + 2)) - 64'd1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc, pc_next, instr;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];
  logic [15:0] disp_latch, sel_val;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm, rv1, rv2, alu_b, alu_result, wb_data;
  alu_op_t     alu_op;
  logic        reg_we, mem_we, mem_to_reg, use_imm, is_beq;

  // Fixed program; unused slots are NOPs (addi x0,x0,0).
  always_comb begin
    instr = NOP;
    case (int'(pc[IW+1:2]))
      0:       instr = 32'h0050_0093;  // addi x1,x0,5
      1:       instr = 32'h0030_0113;  // addi x2,x0,3
      2:       instr = 32'h0020_81B3;  // add  x3,x1,x2
      3:       instr = 32'h4020_8233;  // sub  x4,x1,x2
      4:       instr = 32'h0020_F2B3;  // and  x5,x1,x2
      5:       instr = 32'h0020_E333;  // or   x6,x1,x2
      6:       instr = 32'h0030_2223;  // sw   x3,4(x0)
      7:       instr = 32'h0040_2383;  // lw   x7,4(x0)
      8:       instr = 32'h0033_8463;  // beq  x7,x3,+8
      9:       instr = 32'h00F0_0213;  // addi x4,x0,15
      10:      instr = 32'h0000_0063;  // beq  x0,x0,0
      default: instr = NOP;
    endcase
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign rv1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // Any opcode/funct combination not matched here leaves every enable low,
  // which makes it a NOP.
  always_comb begin
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    use_imm    = 1'b0;
    is_beq     = 1'b0;
    imm        = imm_i;
    case (opcode)
      OPC_OP: begin
        if (f3 == F3_ADDSUB && f7 == F7_BASE) begin
          reg_we = 1'b1;
          alu_op = ALU_ADD;
        end else if (f3 == F3_ADDSUB && f7 == F7_SUB) begin
          reg_we = 1'b1;
          alu_op = ALU_SUB;
        end else if (f3 == F3_AND && f7 == F7_BASE) begin
          reg_we = 1'b1;
          alu_op = ALU_AND;
        end else if (f3 == F3_OR && f7 == F7_BASE) begin
          reg_we = 1'b1;
          alu_op = ALU_OR;
        end
      end
      OPC_OPIMM: begin
        if (f3 == F3_ADDSUB) begin
          reg_we  = 1'b1;
          use_imm = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (f3 == F3_WORD) begin
          reg_we     = 1'b1;
          use_imm    = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3 == F3_WORD) begin
          mem_we  = 1'b1;
          use_imm = 1'b1;
          imm     = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (f3 == F3_BEQ) is_beq = 1'b1;
      end
      default: ;
    endcase
  end

  // The ALU also forms the LW/SW address (rs1 + offset).
  always_comb begin
    alu_b = use_imm ? imm : rv2;
    unique case (alu_op)
      ALU_SUB: alu_result = rv1 - alu_b;
      ALU_AND: alu_result = rv1 & alu_b;
      ALU_OR:  alu_result = rv1 | alu_b;
      default: alu_result = rv1 + alu_b;
    endcase
  end

  assign wb_data = mem_to_reg ? dmem[alu_result[DW+1:2]] : alu_result;
  assign pc_next = (is_beq && rv1 == rv2) ? pc + imm_b : pc + 32'd4;

  always_comb begin
    unique case (sel)
      2'b00:   sel_val = regs[3][15:0];
      2'b01:   sel_val = regs[4][15:0];
      2'b10:   sel_val = regs[5][15:0];
      default: sel_val = regs[6][15:0];
    endcase
  end

  // Architectural state. The display latch samples the register file before
  // this edge's writeback lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= '0;
      disp_latch <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      pc <= pc_next & PC_MASK;
      if (reg_we && rd != 5'd0) regs[rd] <= wb_data;
      if (mem_we) dmem[alu_result[DW+1:2]] <= rv2;
      if (wr) disp_latch <= sel_val;
    end
  end

  riscv_seg_display #(
    .DIG_DIV_BITS(DIG_DIV_BITS)
  ) u_seg (
    .clk    (clk),
    .reset  (reset),
    .value  (disp_latch),
    .anode  (anode),
    .cathode(cathode)
  );

endmodule

// File: tb/tb_riscv.sv
// tb_riscv: directed self-checking bench for the riscv board top.
// Runs the fixed program, reads each displayed digit back off the scanned
// anode/cathode outputs and compares against hand-computed register values.
module tb_riscv;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       wr = 1'b0;
  logic [3:0] anode;
  logic [6:0] cathode;

  int checks = 0;
  int failures = 0;

  riscv #(
    .DIG_DIV_BITS(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .wr     (wr),
    .anode  (anode),
    .cathode(cathode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Segment patterns typed from the hex encoding table.
  function automatic logic [6:0] expSeg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] expCath(input logic [15:0] value, input int d);
    logic [15:0] upper;
    upper = value >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0000) return 7'b1111111;
`endif
    return expSeg(upper[3:0]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs (called just after a falling edge) then let cycles elapse.
  task automatic applyStimulus(input logic r, input logic [1:0] s, input logic w, input int cycles);
    reset = r;
    sel   = s;
    wr    = w;
    repeat (cycles) @(negedge clk);
  endtask

  // Wait for each digit to be scanned and compare its segments.
  task automatic readDisplay(input string tag, input logic [15:0] value);
    logic       found;
    logic [3:0] want;
    for (int d = 0; d < 4; d++) begin
      want  = ~(4'b0001 << d);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        if (anode == want) found = 1'b1;
        else @(negedge clk);
      end
      checkOutput($sformatf("%s_found%0d", tag, d), {31'd0, found}, 32'd1);
      if (found) checkOutput($sformatf("%s_d%0d", tag, d), {25'd0, cathode}, {25'd0, expCath(value, d)});
    end
  endtask

  initial begin
    logic [3:0] exp_an;

    // Reset held for three edges.
    applyStimulus(1'b0, 2'b00, 1'b0, 3);
    checkOutput("rst_anode", {28'd0, anode}, 32'h0000_000E);
    checkOutput("rst_cathode", {25'd0, cathode}, {25'd0, 7'b1000000});

    // Release with wr=0: anode walks 1110,1101,1011,0111 (4 cycles each),
    // every digit shows 0.
    reset = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((n - 1) >> 2) & 3));
      checkOutput($sformatf("scan_anode_%0d", n), {28'd0, anode}, {28'd0, exp_an});
      checkOutput($sformatf("scan_zero_%0d", n), {25'd0, cathode}, {25'd0, 7'b1000000});
    end

    // Program has finished; capture each result register.
    applyStimulus(1'b1, 2'b00, 1'b1, 6);
    readDisplay("x3", 16'h0008);
    applyStimulus(1'b1, 2'b01, 1'b1, 6);
    readDisplay("x4", 16'h0002);
    applyStimulus(1'b1, 2'b10, 1'b1, 6);
    readDisplay("x5", 16'h0001);
    applyStimulus(1'b1, 2'b11, 1'b1, 6);
    readDisplay("x6", 16'h0007);

    // Latch holds 0007 while sel moves.
    applyStimulus(1'b1, 2'b11, 1'b0, 2);
    applyStimulus(1'b1, 2'b00, 1'b0, 40);
    readDisplay("hold", 16'h0007);
    applyStimulus(1'b1, 2'b10, 1'b0, 25);
    readDisplay("hold2", 16'h0007);

    // Reset, run 4 instructions, reset again mid-program.
    applyStimulus(1'b0, 2'b00, 1'b0, 1);
    checkOutput("midrst_anode", {28'd0, anode}, 32'h0000_000E);
    applyStimulus(1'b1, 2'b00, 1'b0, 4);
    applyStimulus(1'b0, 2'b00, 1'b0, 1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1);
    readDisplay("cleared", 16'h0000);
    applyStimulus(1'b1, 2'b00, 1'b0, 12);
    applyStimulus(1'b1, 2'b01, 1'b1, 4);
    readDisplay("restart_x4", 16'h0002);
    applyStimulus(1'b1, 2'b00, 1'b1, 4);
    readDisplay("restart_x3", 16'h0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
